// File: rtl/eer_pkt_pkg.sv
// rtl/eer_pkt_pkg.sv - packet type codes, parser states and CH info record shared with the CH selector
package eer_pkt_pkg;

    localparam int WORD_W = 16;
    localparam int MEM_W  = 8;

    localparam logic [7:0] PKT_TYPE_CH_ADV = 8'h01;
    localparam logic [7:0] PKT_TYPE_DATA   = 8'h02;
    localparam logic [7:0] PKT_TYPE_JOIN   = 8'h03;

    localparam int CH_ADV_WORDS = 4;

    typedef enum logic [1:0] {
        S_HDR,
        S_BODY,
        S_FLUSH,
        S_EMIT
    } parser_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] CH_ID;
        logic [WORD_W-1:0] CH_Hops;
        logic [WORD_W-1:0] CH_QValue;
    } ch_info_t;

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - big-endian byte-pair to word assembler with hi/lo phase tracking
module byte_word_packer #(
    parameter int MEM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   accept,
    input  logic [MEM_WIDTH-1:0]   in_data,
    input  logic                   in_last,
    output logic                   word_valid,
    output logic [2*MEM_WIDTH-1:0] word,
    output logic                   last_on_hi
);

    logic                 lo_phase_q, lo_phase_d;
    logic [MEM_WIDTH-1:0] hi_q, hi_d;

    // Any in_last realigns to the hi phase so the next packet starts clean.
    always_comb begin
        lo_phase_d = lo_phase_q;
        hi_d       = hi_q;
        if (accept) begin
            if (!lo_phase_q) begin
                hi_d = in_data;
            end
            lo_phase_d = !lo_phase_q && !in_last;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lo_phase_q <= 1'b0;
            hi_q       <= '0;
        end else begin
            lo_phase_q <= lo_phase_d;
            hi_q       <= hi_d;
        end
    end

    assign word_valid = accept && lo_phase_q;
    assign word       = {hi_q, in_data};
    assign last_on_hi = accept && !lo_phase_q && in_last;

endmodule

// File: rtl/ch_adv_parser.sv
// rtl/ch_adv_parser.sv - frames byte-stream packets and forwards CH advertisements to the KCH selector
module ch_adv_parser
    import eer_pkt_pkg::*;
#(
    parameter int         WORD_WIDTH  = 16,
    parameter int         MEM_WIDTH   = 8,
    parameter logic [7:0] CH_ADV_TYPE = PKT_TYPE_CH_ADV,
    parameter int         CH_ADV_LEN  = CH_ADV_WORDS
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] own_id,
    input  logic [MEM_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  en_KCH,
    output logic [WORD_WIDTH-1:0] fCH_ID,
    output logic [WORD_WIDTH-1:0] fCH_Hops,
    output logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [7:0]            drop_count
);

    localparam logic [MEM_WIDTH-1:0] ADV_LEN = MEM_WIDTH'(CH_ADV_LEN);

    parser_state_e          state_q, state_d;
    logic [MEM_WIDTH-1:0]   type_q, type_d;
    logic [MEM_WIDTH-1:0]   len_q, len_d;
    logic [MEM_WIDTH-1:0]   cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0]   cnt_next;
    logic [WORD_WIDTH-1:0]  id_q, id_d;
    logic [WORD_WIDTH-1:0]  hops_q, hops_d;
    logic [WORD_WIDTH-1:0]  qv_q, qv_d;
    ch_info_t               out_q, out_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   drop;

    logic                   accept;
    logic                   word_valid;
    logic [WORD_WIDTH-1:0]  word;
    logic                   last_on_hi;
    logic [MEM_WIDTH-1:0]   hdr_type;
    logic [MEM_WIDTH-1:0]   hdr_len;

    assign in_ready = (state_q != S_EMIT);
    assign accept   = in_valid && in_ready;
    assign hdr_type = word[WORD_WIDTH-1 -: MEM_WIDTH];
    assign hdr_len  = word[MEM_WIDTH-1:0];
    assign cnt_next = cnt_q + 1'b1;

    byte_word_packer #(
        .MEM_WIDTH (MEM_WIDTH)
    ) u_packer (
        .clk        (clk),
        .nrst       (nrst),
        .accept     (accept),
        .in_data    (in_data),
        .in_last    (in_last),
        .word_valid (word_valid),
        .word       (word),
        .last_on_hi (last_on_hi)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        hops_d  = hops_q;
        qv_d    = qv_q;
        out_d   = out_q;
        drop    = 1'b0;

        case (state_q)
            S_HDR: begin
                if (last_on_hi) begin
                    drop = 1'b1;
                end else if (word_valid) begin
                    type_d = hdr_type;
                    len_d  = hdr_len;
                    cnt_d  = 1;
                    if (hdr_len == '0 || in_last) begin
                        drop = 1'b1;
                    end else if (hdr_len == 1) begin
                        // A header-only packet that keeps streaming is already complete.
                        drop    = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (last_on_hi) begin
                    drop    = 1'b1;
                    state_d = S_HDR;
                end else if (word_valid) begin
                    cnt_d = cnt_next;
                    case (cnt_q)
                        1:       id_d   = word;
                        2:       hops_d = word;
                        3:       qv_d   = word;
                        default: ;
                    endcase
                    if (cnt_next == len_q) begin
                        if (!in_last) begin
                            drop    = 1'b1;
                            state_d = S_FLUSH;
                        end else if (type_q == CH_ADV_TYPE && len_q == ADV_LEN && id_q != own_id) begin
                            // The Q word arrives on this very edge, so take it from the bus.
                            out_d.CH_ID     = id_q;
                            out_d.CH_Hops   = sat_inc(hops_q);
                            out_d.CH_QValue = word;
                            state_d         = S_EMIT;
                        end else begin
                            drop    = 1'b1;
                            state_d = S_HDR;
                        end
                    end else if (in_last) begin
                        drop    = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_FLUSH: begin
                if (accept && in_last) begin
                    state_d = S_HDR;
                end
            end
            S_EMIT: begin
                state_d = S_HDR;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_HDR;
            type_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            hops_q     <= '0;
            qv_q       <= '0;
            out_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            hops_q     <= hops_d;
            qv_q       <= qv_d;
            out_q      <= out_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign en_KCH     = (state_q == S_EMIT);
    assign fCH_ID     = out_q.CH_ID;
    assign fCH_Hops   = out_q.CH_Hops;
    assign fCH_QValue = out_q.CH_QValue;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ch_adv_parser.sv
// tb/tb_ch_adv_parser.sv - self-checking bench for ch_adv_parser against a packet-level model
module tb_ch_adv_parser;

    logic        clk;
    logic        nrst;
    logic [15:0] own_id;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        en_KCH;
    logic [15:0] fCH_ID;
    logic [15:0] fCH_Hops;
    logic [15:0] fCH_QValue;
    logic [7:0]  drop_count;

    ch_adv_parser dut (
        .clk        (clk),
        .nrst       (nrst),
        .own_id     (own_id),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .en_KCH     (en_KCH),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: bytes between in_last markers are judged as a whole.
    logic [7:0]  pkt[$];
    logic        m_en;
    logic [15:0] m_id, m_hops, m_q;
    int          m_drop;

    task automatic model_drop();
        if (m_drop < 255) m_drop++;
    endtask

    task automatic eval_pkt();
        int pos;
        int r;
        int ln;
        logic [15:0] id, hops;
        pos = 0;
        forever begin
            r = pkt.size() - pos;
            if (r < 2) begin
                model_drop();
                break;
            end
            ln = int'(pkt[pos+1]);
            if (ln == 0) begin
                model_drop();
                pos += 2;
                if (pos == pkt.size()) break;
                continue;
            end
            if (r != 2 * ln) begin
                model_drop();
                break;
            end
            if (pkt[pos] == 8'h01 && ln == 4) begin
                id   = {pkt[pos+2], pkt[pos+3]};
                hops = {pkt[pos+4], pkt[pos+5]};
                if (id != own_id) begin
                    m_en   = 1'b1;
                    m_id   = id;
                    m_hops = (hops == 16'hFFFF) ? 16'hFFFF : hops + 16'd1;
                    m_q    = {pkt[pos+6], pkt[pos+7]};
                end else begin
                    model_drop();
                end
            end else begin
                model_drop();
            end
            break;
        end
    endtask

    initial begin
        m_en = 1'b0; m_id = '0; m_hops = '0; m_q = '0; m_drop = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                pkt.delete();
                m_en = 1'b0; m_id = '0; m_hops = '0; m_q = '0; m_drop = 0;
            end
            chk("en_KCH", {31'd0, en_KCH}, {31'd0, m_en});
            chk("fCH_ID", {16'd0, fCH_ID}, {16'd0, m_id});
            chk("fCH_Hops", {16'd0, fCH_Hops}, {16'd0, m_hops});
            chk("fCH_QValue", {16'd0, fCH_QValue}, {16'd0, m_q});
            if (nrst) chk("in_ready", {31'd0, in_ready}, {31'd0, !m_en});
            if (pkt.size() == 0) chk("drop_count", {24'd0, drop_count}, m_drop);
            m_en = 1'b0;
            if (nrst && in_valid && in_ready) begin
                pkt.push_back(in_data);
                if (in_last) begin
                    eval_pkt();
                    pkt.delete();
                end
            end
        end
    end

    logic [7:0] tx[$];

    task automatic send_byte(input logic [7:0] b, input logic last);
        logic ok;
        int   waited;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 8) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_pkt(input logic with_last);
        for (int i = 0; i < tx.size(); i++) begin
            send_byte(tx[i], with_last && (i == tx.size() - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst     = 1'b0;
        own_id   = 16'h0003;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        chk("rst_en_KCH", {31'd0, en_KCH}, 32'd0);
        chk("rst_fCH_ID", {16'd0, fCH_ID}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(1);

        tx = '{8'h01, 8'h04, 8'h00, 8'h07, 8'h00, 8'h02, 8'h01, 8'hF4};
        send_pkt(1'b1);
        chk("adv_en", {31'd0, en_KCH}, 32'd1);
        chk("adv_id", {16'd0, fCH_ID}, 32'h0007);
        chk("adv_hops", {16'd0, fCH_Hops}, 32'h0003);
        chk("adv_q", {16'd0, fCH_QValue}, 32'h01F4);
        chk("adv_ready", {31'd0, in_ready}, 32'd0);
        chk("adv_drop", {24'd0, drop_count}, 32'd0);
        idle(2);

        tx = '{8'h01, 8'h04, 8'h00, 8'h03, 8'h00, 8'h02, 8'h01, 8'hF4};
        send_pkt(1'b1);
        idle(2);
        chk("self_drop", {24'd0, drop_count}, 32'd1);
        chk("self_id_kept", {16'd0, fCH_ID}, 32'h0007);

        tx = '{8'h01, 8'h04, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'h00, 8'h10};
        send_pkt(1'b1);
        chk("sat_hops", {16'd0, fCH_Hops}, 32'hFFFF);
        idle(2);

        tx = '{8'h01, 8'h04, 8'h00, 8'h06, 8'h00, 8'h01, 8'h00};
        send_pkt(1'b1);
        tx = '{8'h01, 8'h04, 8'h00, 8'h09, 8'h00, 8'h01, 8'h00, 8'h20};
        send_pkt(1'b1);
        chk("early_next_id", {16'd0, fCH_ID}, 32'h0009);
        chk("early_drop", {24'd0, drop_count}, 32'd2);
        idle(2);

        tx = '{8'h01, 8'h04, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h00, 8'h02,
               8'h00, 8'h03, 8'h00, 8'h04};
        send_pkt(1'b1);
        tx = '{8'h01, 8'h04, 8'h00, 8'h0B, 8'h00, 8'h03, 8'h00, 8'h30};
        send_pkt(1'b1);
        chk("long_next_id", {16'd0, fCH_ID}, 32'h000B);
        chk("long_next_hops", {16'd0, fCH_Hops}, 32'h0004);
        chk("long_drop", {24'd0, drop_count}, 32'd3);
        idle(2);

        tx = '{8'h02, 8'h02, 8'h00, 8'h0C};
        send_pkt(1'b1);
        idle(2);
        chk("type_drop", {24'd0, drop_count}, 32'd4);
        chk("type_id_kept", {16'd0, fCH_ID}, 32'h000B);

        tx = '{8'h01, 8'h04, 8'h00, 8'h0D};
        send_pkt(1'b0);
        nrst = 1'b0;
        #1;
        chk("midrst_id", {16'd0, fCH_ID}, 32'd0);
        chk("midrst_drop", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(1);
        tx = '{8'h01, 8'h04, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h01};
        send_pkt(1'b1);
        chk("post_rst_id", {16'd0, fCH_ID}, 32'h000E);
        chk("post_rst_hops", {16'd0, fCH_Hops}, 32'h0001);
        chk("post_rst_drop", {24'd0, drop_count}, 32'd0);
        idle(2);

        for (int k = 0; k < 260; k++) begin
            tx = '{8'h02, 8'h00};
            send_pkt(1'b1);
        end
        idle(2);
        chk("drop_sat", {24'd0, drop_count}, 32'h00FF);
        chk("drop_sat_id_kept", {16'd0, fCH_ID}, 32'h000E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
